signal_sync_filter: RTL and testbench



---
 rtl/signal_sync_filter.sv | 69 ++++++
 tb/tb_signal_sync_filter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/signal_sync_filter.sv
// signal_sync_filter: multi-channel synchroniser with per-channel glitch filter and edge pulses
// Ports: clk (sole clock), rst_n (synchronous, active-low), sig[Width] (asynchronous inputs),
//        sigout[Width] (synchronised, filtered level), rise/fall[Width] (1-cycle sigout edge pulses)
// Optional feature: define SIGNAL_SYNC_FILTER_EDGE_EN to drive rise/fall; otherwise both are tied to 0.
module signal_sync_filter #(
    parameter int               Width        = 1,
    parameter int               Depth        = 2,
    parameter int               FilterCycles = 4,
    parameter logic [Width-1:0] ResetValue   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Width-1:0] sig,
    output logic [Width-1:0] sigout,
    output logic [Width-1:0] rise,
    output logic [Width-1:0] fall
);
    logic [Width-1:0] stage [Depth];
    logic [Width-1:0] s;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < Depth; k++) stage[k] <= ResetValue;
        end else begin
            stage[0] <= sig;
            for (int k = 1; k < Depth; k++) stage[k] <= stage[k-1];
        end
    end
    assign s = stage[Depth-1];
    generate
        if (FilterCycles == 0) begin : g_bypass
            assign sigout = s;
`ifdef SIGNAL_SYNC_FILTER_EDGE_EN
            // previous synchronised level, so edges line up with the cycle sigout changes
            logic [Width-1:0] prev;
            always_ff @(posedge clk) prev <= !rst_n ? ResetValue : s;
            assign rise = s & ~prev;
            assign fall = ~s & prev;
`else
            assign rise = '0;
            assign fall = '0;
`endif
        end else begin : g_filter
            localparam int CW = $clog2(FilterCycles + 1);
            logic [Width-1:0] level;
            logic [Width-1:0] hit;
            for (genvar i = 0; i < Width; i++) begin : g_ch
                logic [CW-1:0] cnt;
                // last differing cycle of the run: output takes the new level on this edge
                assign hit[i] = s[i] != level[i] && cnt == CW'(FilterCycles - 1);
                always_ff @(posedge clk) cnt <= (!rst_n || s[i] == level[i] || hit[i]) ? '0 : cnt + 1'b1;
            end
            always_ff @(posedge clk) level <= !rst_n ? ResetValue : level ^ hit;
            assign sigout = level;
`ifdef SIGNAL_SYNC_FILTER_EDGE_EN
            logic [Width-1:0] r;
            logic [Width-1:0] f;
            always_ff @(posedge clk) begin
                r <= !rst_n ? '0 : hit & s;
                f <= !rst_n ? '0 : hit & ~s;
            end
            assign rise = r;
            assign fall = f;
`else
            assign rise = '0;
            assign fall = '0;
`endif
        end
    endgenerate
endmodule

// File: tb/tb_signal_sync_filter.sv
// tb_signal_sync_filter: directed vector bench for signal_sync_filter in three configurations
module tb_signal_sync_filter;
`ifdef SIGNAL_SYNC_FILTER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif
    typedef struct {
        logic s;
        logic so;
        logic r;
        logic f;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n, a_sig, a_so, a_r, a_f;
    logic       c_rst_n, c_sig, c_so, c_r, c_f;
    logic       b_rst_n;
    logic [3:0] b_sig, b_so, b_r, b_f;

    int n_vec = 0;
    int n_err = 0;

    signal_sync_filter #(.Width(1), .Depth(2), .FilterCycles(4), .ResetValue(1'b0)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .sig(a_sig), .sigout(a_so), .rise(a_r), .fall(a_f));
    signal_sync_filter #(.Width(4), .Depth(3), .FilterCycles(0), .ResetValue(4'b0000)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .sig(b_sig), .sigout(b_so), .rise(b_r), .fall(b_f));
    signal_sync_filter #(.Width(1), .Depth(2), .FilterCycles(4), .ResetValue(1'b1)) dut_c (
        .clk(clk), .rst_n(c_rst_n), .sig(c_sig), .sigout(c_so), .rise(c_r), .fall(c_f));

    task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t tv [31];
    logic [30:0] sp, sop, rp, fp;

    initial begin
        a_rst_n = 1'b0; a_sig = 1'b0;
        b_rst_n = 1'b0; b_sig = 4'b0;
        c_rst_n = 1'b0; c_sig = 1'b0;
        // step 1 = MSB: held rise, held fall, 3-cycle glitch, bounce 1,0,1...
        sp  = 31'b1111111_0000000_111_00000_1_0_1111111;
        sop = 31'b00000_1111111_00000000000000000_11;
        rp  = 31'b00000_1_00000000000000000000000_1_0;
        fp  = 31'b000000000000_1_000000000000000000;
        for (int i = 0; i < 31; i++)
            tv[i] = '{sp[30-i], sop[30-i], rp[30-i] & EDGE, fp[30-i] & EDGE};
        @(negedge clk);
        step();
        step();
        chk("a reset sigout", a_so, 0);
        chk("a reset rise", a_r, 0);
        chk("a reset fall", a_f, 0);
        a_rst_n = 1'b1;
        for (int i = 0; i < 31; i++) begin
            a_sig = tv[i].s;
            step();
            chk($sformatf("tbl%0d sigout", i + 1), a_so, tv[i].so);
            chk($sformatf("tbl%0d rise", i + 1), a_r, tv[i].r);
            chk($sformatf("tbl%0d fall", i + 1), a_f, tv[i].f);
        end
        // reset while sigout=1: level returns to 0 with no fall pulse
        a_rst_n = 1'b0; a_sig = 1'b0;
        step();
        chk("rst from high sigout", a_so, 0);
        chk("rst from high fall", a_f, 0);
        chk("rst from high rise", a_r, 0);
        // reset with a partial count of 2 discards it
        a_rst_n = 1'b1; a_sig = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("pre-midrst sigout", a_so, 0);
        a_rst_n = 1'b0;
        step();
        chk("midrst sigout", a_so, 0);
        chk("midrst rise", a_r, 0);
        a_rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("postrst%0d sigout", k), a_so, (k >= 6) ? 1 : 0);
            chk($sformatf("postrst%0d rise", k), a_r, (k == 6) ? EDGE : 0);
        end
        // four channels, filter bypassed, depth 3
        step();
        chk("b reset sigout", b_so, 4'b0);
        b_rst_n = 1'b1; b_sig = 4'b1010;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("b1 %0d sigout", k), b_so, (k >= 3) ? 4'b1010 : 4'b0000);
            chk($sformatf("b1 %0d rise", k), b_r, (k == 3 && EDGE) ? 4'b1010 : 4'b0000);
            chk($sformatf("b1 %0d fall", k), b_f, 4'b0000);
        end
        b_sig = 4'b0110;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("b2 %0d sigout", k), b_so, (k >= 3) ? 4'b0110 : 4'b1010);
            chk($sformatf("b2 %0d rise", k), b_r, (k == 3 && EDGE) ? 4'b0100 : 4'b0000);
            chk($sformatf("b2 %0d fall", k), b_f, (k == 3 && EDGE) ? 4'b1000 : 4'b0000);
        end
        // reset value 1, input held low: one fall pulse after Depth+FilterCycles
        step();
        chk("c reset sigout", c_so, 1);
        chk("c reset fall", c_f, 0);
        c_rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("c %0d sigout", k), c_so, (k < 6) ? 1 : 0);
            chk($sformatf("c %0d fall", k), c_f, (k == 6) ? EDGE : 0);
            chk($sformatf("c %0d rise", k), c_r, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
